// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared word, RAM state and arbitration grant types for the memory subsystem
package cpu_types_pkg;
    typedef logic [31:0] word_t;
    typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
    typedef enum logic [1:0] {I, DR, DW} arb_kind_t;
endpackage

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin select of the first set request at or after start
module rr_picker #(
    parameter int N  = 2,
    parameter int IW = N > 1 ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] start,
    output logic          valid,
    output logic [IW-1:0] idx
);
    logic [IW-1:0] k;
    // scan from the far end so the candidate closest to start is written last and wins
    always_comb begin
        valid = |req;
        idx = '0;
        k = '0;
        for (int i = N - 1; i >= 0; i--) begin
            k = IW'((int'(start) + i) % N);
            if (req[k]) idx = k;
        end
    end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates every CPU's icache/dcache requests onto one RAM port, one access at a time
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int CPUS    = 2,
    parameter int MAXWAIT = 8
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic [CPUS-1:0]   iREN,
    input  logic [CPUS-1:0]   dREN,
    input  logic [CPUS-1:0]   dWEN,
    input  logic [CPUS*32-1:0] iaddr,
    input  logic [CPUS*32-1:0] daddr,
    input  logic [CPUS*32-1:0] dstore,
    output logic [CPUS-1:0]   iwait,
    output logic [CPUS-1:0]   dwait,
    output logic [CPUS*32-1:0] iload,
    output logic [CPUS*32-1:0] dload,
    output logic              ramREN,
    output logic              ramWEN,
    output word_t             ramaddr,
    output word_t             ramstore,
    input  word_t             ramload,
    input  ramstate_t         ramstate
);
    localparam int CW = CPUS > 1 ? $clog2(CPUS) : 1;
    localparam int SW = $clog2(MAXWAIT + 1);

    typedef enum logic {IDLE, SERVE} arb_state_t;

    arb_state_t              state_q, state_d;
    arb_kind_t               kind_q, kind_d;
    logic [CW-1:0]           cpu_q, cpu_d, rr_q, rr_d;
    logic [CPUS-1:0][SW-1:0] starve_q, starve_d;
    logic [CPUS-1:0]         starving;
    logic                    va, vb, vc, live;
    logic [CW-1:0]           ia, ib, ic;

    for (genvar s = 0; s < CPUS; s++) begin : g_starve
        assign starving[s] = iREN[s] && starve_q[s] == SW'(MAXWAIT);
    end

    rr_picker #(.N(CPUS), .IW(CW)) u_pick_a (.req(starving),    .start(rr_q), .valid(va), .idx(ia));
    rr_picker #(.N(CPUS), .IW(CW)) u_pick_b (.req(dREN | dWEN), .start(rr_q), .valid(vb), .idx(ib));
    rr_picker #(.N(CPUS), .IW(CW)) u_pick_c (.req(iREN),        .start(rr_q), .valid(vc), .idx(ic));

    // the granted request must still be asserted, otherwise the access is abandoned
    assign live = kind_q == I ? iREN[cpu_q] : kind_q == DW ? dWEN[cpu_q] : dREN[cpu_q];

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= IDLE;
            kind_q   <= I;
            cpu_q    <= '0;
            rr_q     <= '0;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            kind_q   <= kind_d;
            cpu_q    <= cpu_d;
            rr_q     <= rr_d;
            starve_q <= starve_d;
        end
    end

    always_comb begin
        state_d = state_q;
        kind_d  = kind_q;
        cpu_d   = cpu_q;
        rr_d    = rr_q;
        if (state_q == IDLE) begin
            if (va || vb || vc) begin
                state_d = SERVE;
                cpu_d   = va ? ia : vb ? ib : ic;
                kind_d  = va || !vb ? I : dWEN[ib] ? DW : DR;
            end
        end else if (!live || ramstate == ACCESS) begin
            state_d = IDLE;
            rr_d    = live ? CW'((int'(cpu_q) + 1) % CPUS) : rr_q;
        end
    end

    always_comb begin
        starve_d = starve_q;
        for (int c = 0; c < CPUS; c++) begin
            if (!iREN[CW'(c)])
                starve_d[CW'(c)] = '0;
            else if (state_q == IDLE)
                starve_d[CW'(c)] = cpu_d == CW'(c) && kind_d == I ? '0 :
                                   starve_q[CW'(c)] == SW'(MAXWAIT) ? starve_q[CW'(c)] :
                                   starve_q[CW'(c)] + SW'(1);
        end
    end

    always_comb begin
        iwait    = '1;
        dwait    = '1;
        iload    = '0;
        dload    = '0;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        if (state_q == SERVE) begin
            ramaddr  = kind_q == I ? iaddr[32*int'(cpu_q) +: 32] : daddr[32*int'(cpu_q) +: 32];
            ramstore = kind_q == DW ? dstore[32*int'(cpu_q) +: 32] : '0;
            ramREN   = live && kind_q != DW;
            ramWEN   = live && kind_q == DW;
            if (live && ramstate == ACCESS) begin
                if (kind_q == I) begin
                    iwait[cpu_q] = 1'b0;
                    iload[32*int'(cpu_q) +: 32] = ramload;
                end else begin
                    dwait[cpu_q] = 1'b0;
                    if (kind_q == DR) dload[32*int'(cpu_q) +: 32] = ramload;
                end
            end
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter against a transaction-level model
module tb_mem_arbiter;
    import cpu_types_pkg::*;
    localparam int CPUS = 2;
    localparam int MAXWAIT = 8;

    logic CLK = 1'b0;
    logic nRST = 1'b0;
    logic [CPUS-1:0] iREN = '0, dREN = '0, dWEN = '0, iwait, dwait;
    logic [CPUS*32-1:0] iaddr = '0, daddr = '0, dstore = '0, iload, dload;
    logic ramREN, ramWEN;
    word_t ramaddr, ramstore, ramload = '0;
    ramstate_t ramstate = FREE;

    int checks = 0, errors = 0;

    // model: an outstanding grant (cpu, kind 0=I 1=DR 2=DW), round-robin pointer, starvation ages
    bit m_busy;
    int m_cpu, m_kind, m_rr;
    int m_starve[CPUS];

    mem_arbiter #(.CPUS(CPUS), .MAXWAIT(MAXWAIT)) dut (
        .CLK(CLK), .nRST(nRST), .iREN(iREN), .dREN(dREN), .dWEN(dWEN),
        .iaddr(iaddr), .daddr(daddr), .dstore(dstore), .iwait(iwait), .dwait(dwait),
        .iload(iload), .dload(dload), .ramREN(ramREN), .ramWEN(ramWEN),
        .ramaddr(ramaddr), .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        m_busy = 0;
        m_cpu = 0;
        m_kind = 0;
        m_rr = 0;
        for (int p = 0; p < CPUS; p++) m_starve[p] = 0;
    endfunction

    function automatic bit live_m();
        return m_kind == 0 ? iREN[m_cpu] : m_kind == 2 ? dWEN[m_cpu] : dREN[m_cpu];
    endfunction

    function automatic void arbitrate(output int c, output int k);
        c = 0;
        k = 0;
        for (int pass = 0; pass < 3; pass++)
            for (int off = 0; off < CPUS; off++) begin
                int p = (m_rr + off) % CPUS;
                bit hit = pass == 0 ? (iREN[p] && m_starve[p] == MAXWAIT) :
                          pass == 1 ? (dREN[p] || dWEN[p]) : iREN[p];
                if (hit) begin
                    c = p;
                    k = pass == 1 ? (dWEN[p] ? 2 : 1) : 0;
                    return;
                end
            end
    endfunction

    function automatic void model_edge();
        int c, k;
        if (!nRST) begin
            model_reset();
            return;
        end
        if (!m_busy) begin
            if ((iREN | dREN | dWEN) != 0) begin
                arbitrate(c, k);
                for (int p = 0; p < CPUS; p++)
                    m_starve[p] = !iREN[p] || (p == c && k == 0) ? 0 :
                                  (m_starve[p] + 1 > MAXWAIT ? MAXWAIT : m_starve[p] + 1);
                m_busy = 1;
                m_cpu = c;
                m_kind = k;
            end else
                for (int p = 0; p < CPUS; p++) m_starve[p] = 0;
        end else begin
            for (int p = 0; p < CPUS; p++) if (!iREN[p]) m_starve[p] = 0;
            if (!live_m()) m_busy = 0;
            else if (ramstate == ACCESS) begin
                m_busy = 0;
                m_rr = (m_cpu + 1) % CPUS;
            end
        end
    endfunction

    task automatic check_outputs();
        logic [CPUS-1:0] ew_i = '1, ew_d = '1;
        logic [CPUS*32-1:0] el_i = '0, el_d = '0;
        logic eren = 0, ewen = 0;
        word_t eaddr = '0, estore = '0;
        if (nRST && m_busy) begin
            bit lv = live_m();
            eaddr  = m_kind == 0 ? iaddr[32*m_cpu +: 32] : daddr[32*m_cpu +: 32];
            estore = dstore[32*m_cpu +: 32];
            eren = lv && m_kind != 2;
            ewen = lv && m_kind == 2;
            if (lv && ramstate == ACCESS) begin
                if (m_kind == 0) begin
                    ew_i[m_cpu] = 1'b0;
                    el_i[32*m_cpu +: 32] = ramload;
                end else begin
                    ew_d[m_cpu] = 1'b0;
                    if (m_kind == 1) el_d[32*m_cpu +: 32] = ramload;
                end
            end
        end
        chk("iwait", 64'(iwait), 64'(ew_i));
        chk("dwait", 64'(dwait), 64'(ew_d));
        chk("iload", iload, el_i);
        chk("dload", dload, el_d);
        chk("ram_en", {62'd0, ramREN, ramWEN}, {62'd0, eren, ewen});
        if (eren || ewen) chk("ramaddr", 64'(ramaddr), 64'(eaddr));
        if (ewen) chk("ramstore", 64'(ramstore), 64'(estore));
    endtask

    // called at a falling edge with inputs already applied; returns at the next falling edge
    task automatic step();
        #1 check_outputs();
        @(posedge CLK);
        model_edge();
        @(negedge CLK);
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        model_reset();
        step();
        step();
        iREN = '0;
        dREN = '0;
        dWEN = '0;
        nRST = 1'b1;
    endtask

    task automatic randomize_inputs();
        int r;
        for (int p = 0; p < CPUS; p++) begin
            if ($urandom_range(0, 5) == 0) iREN[p] = ~iREN[p];
            if ($urandom_range(0, 5) == 0) dREN[p] = ~dREN[p];
            if ($urandom_range(0, 8) == 0) dWEN[p] = ~dWEN[p];
            iaddr[32*p +: 32]  = $urandom;
            daddr[32*p +: 32]  = $urandom;
            dstore[32*p +: 32] = $urandom;
        end
        r = $urandom_range(0, 5);
        ramstate = r >= 3 ? ACCESS : ramstate_t'(r);
        ramload = $urandom;
    endtask

    initial begin
        int found;
        model_reset();
        randomize_inputs();
        @(negedge CLK);
        for (int n = 0; n < 3; n++) begin
            randomize_inputs();
            step();
        end
        do_reset();

        // single icache fetch through two busy cycles
        iREN = 2'b01;
        iaddr[31:0] = 32'h40;
        ramstate = BUSY;
        step();
        #1 chk("t2_busy_iwait", 64'(iwait[0]), 64'd1);
        step();
        step();
        ramstate = ACCESS;
        ramload = 32'hDEADBEEF;
        #1 chk("t2_iwait", 64'(iwait[0]), 64'd0);
        chk("t2_iload", 64'(iload[31:0]), 64'hDEADBEEF);
        chk("t2_ramaddr", 64'(ramaddr), 64'h40);
        step();
        iREN = '0;
        #1 chk("t2_idle_iwait", 64'(iwait), 64'h3);
        step();

        // dcache beats icache in the same arbitration
        iREN = 2'b01;
        dREN = 2'b10;
        daddr[63:32] = 32'h80;
        ramload = 32'h1234;
        step();
        #1 chk("t3_dwait", 64'(dwait), 64'h1);
        chk("t3_iwait", 64'(iwait), 64'h3);
        chk("t3_ramaddr", 64'(ramaddr), 64'h80);
        chk("t3_dload", 64'(dload[63:32]), 64'h1234);
        step();
        dREN = '0;
        step();
        #1 chk("t3_iwait_next", 64'(iwait), 64'h2);
        step();
        iREN = '0;
        step();

        // continuous writes from both CPUs alternate
        do_reset();
        dWEN = 2'b11;
        dstore = {32'hBBBB0001, 32'hAAAA0000};
        ramstate = ACCESS;
        for (int k = 0; k < 4; k++) begin
            step();
            #1 chk("t4_dwait", 64'(dwait), k % 2 == 0 ? 64'h2 : 64'h1);
            chk("t4_ramWEN", 64'(ramWEN), 64'd1);
            chk("t4_ramstore", 64'(ramstore), k % 2 == 0 ? 64'hAAAA0000 : 64'hBBBB0001);
            step();
        end
        dWEN = '0;
        step();

        // starving icache wins on its ninth arbitration
        do_reset();
        dREN = 2'b01;
        iREN = 2'b10;
        ramstate = ACCESS;
        found = 0;
        for (int n = 1; n <= 12 && found == 0; n++) begin
            step();
            #1 if (!iwait[1]) found = n;
            step();
        end
        chk("t5_starve_arb", 64'(found), 64'd9);
        dREN = '0;
        iREN = '0;
        step();

        // write wins over read, abort drops enables and keeps the pointer
        do_reset();
        dWEN = 2'b01;
        dREN = 2'b01;
        ramstate = BUSY;
        step();
        #1 chk("t6_ramWEN", 64'(ramWEN), 64'd1);
        chk("t6_ramREN", 64'(ramREN), 64'd0);
        step();
        dWEN = '0;
        dREN = '0;
        #1 chk("t6_abort_wen", 64'(ramWEN), 64'd0);
        chk("t6_abort_dwait", 64'(dwait), 64'h3);
        step();
        dREN = 2'b01;
        ramstate = ACCESS;
        step();
        step();
        dREN = 2'b10;
        ramstate = BUSY;
        step();
        step();
        dREN = '0;
        #1 chk("t6_abort_ren", 64'(ramREN), 64'd0);
        chk("t6_abort_dwait1", 64'(dwait), 64'h3);
        step();
        dREN = 2'b11;
        ramstate = ACCESS;
        step();
        #1 chk("t6_rr_kept", 64'(dwait), 64'h1);
        step();
        dREN = '0;
        step();

        // randomized traffic with a reset in the middle
        for (int n = 0; n < 4000; n++) begin
            randomize_inputs();
            if (n == 2000) begin
                nRST = 1'b0;
                model_reset();
            end
            if (n == 2004) nRST = 1'b1;
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
